// File: rtl/nebula_pkg.sv
// nebula_pkg: constants, types and helper functions shared by the Nebula
// fabric buffering blocks.
package nebula_pkg;

    localparam int NEBULA_FIFO_DEPTH_DEFAULT = 8;
    localparam int NEBULA_DATA_WIDTH_DEFAULT = 32;

    // The accepted operations in one cycle, encoded as {write, read}.
    typedef enum logic [1:0] {
        FIFO_OP_NONE  = 2'b00,
        FIFO_OP_READ  = 2'b01,
        FIFO_OP_WRITE = 2'b10,
        FIFO_OP_BOTH  = 2'b11
    } fifo_op_t;

    // Status flags, all decoded from the registered occupancy.
    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

    // Width of an occupancy counter that must hold 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer that indexes 0..depth-1 (at least one bit).
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : nebula_pkg

// File: rtl/nebula_fifo_mem.sv
// nebula_fifo_mem: DEPTH x DATA_WIDTH register array with one synchronous
// write port and one asynchronous (combinational) read port.
module nebula_fifo_mem
    import nebula_pkg::*;
#(
    parameter int DATA_WIDTH = NEBULA_DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = NEBULA_FIFO_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [fifo_ptr_w(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [fifo_ptr_w(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word at the write address on an enabled edge.
    // NOTE: the array has no reset; contents are only meaningful once written,
    // and leaving it unreset lets it map onto plain flops or LUT RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            // NOTE: non-blocking assignment so every clocked block samples
            // pre-edge values regardless of evaluation order.
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : nebula_fifo_mem

// File: rtl/nebula_sync_fifo.sv
// nebula_sync_fifo: single-clock show-ahead FIFO with occupancy count and
// programmable almost-full / almost-empty flags. Writes when full and reads
// when empty are dropped. Reset is synchronous, active-low.
// Optional: define NEBULA_FIFO_ASSERTIONS_EN to compile simulation-only
// protocol/consistency assertions.
module nebula_sync_fifo
    import nebula_pkg::*;
#(
    parameter int DATA_WIDTH          = NEBULA_DATA_WIDTH_DEFAULT,
    parameter int DEPTH               = NEBULA_FIFO_DEPTH_DEFAULT,
    parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         full,
    output logic                         almost_full,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [fifo_cnt_w(DEPTH)-1:0] count
);

    localparam int CNT_W = fifo_cnt_w(DEPTH);
    localparam int PTR_W = fifo_ptr_w(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Advance a pointer, wrapping from the last entry back to zero so that
    // non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             wr_acc;
    logic             rd_acc;
    fifo_op_t         op;
    fifo_flags_t      flags;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Flag decode from the registered count only, so flags never disagree
    // with count in the same cycle.
    always_comb begin
        flags              = '0;
        flags.empty        = (count_q == '0);
        flags.full         = (count_q == CNT_FULL);
        flags.almost_full  = (int'(count_q) >= ALMOST_FULL_THRESH);
        flags.almost_empty = (int'(count_q) <= ALMOST_EMPTY_THRESH);
    end

    // Accept decisions and next-state for pointers and count.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // A full FIFO refuses writes even when a read frees a slot this
        // cycle; an empty FIFO refuses reads even with a write arriving.
        wr_acc = wr_en && !flags.full;
        rd_acc = rd_en && !flags.empty;
        op     = fifo_op_t'({wr_acc, rd_acc});

        if (wr_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case (op)
            FIFO_OP_WRITE: count_d = count_q + 1'b1;
            FIFO_OP_READ:  count_d = count_q - 1'b1;
            default:       count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; synchronous reset wins over any request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Writes are suppressed in a reset cycle so reset aborts them cleanly.
    nebula_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && rst_n),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    // Show-ahead head word; forced to zero while empty so stale storage never
    // leaks out.
    assign rd_data      = flags.empty ? '0 : mem_rd_data;
    assign full         = flags.full;
    assign almost_full  = flags.almost_full;
    assign empty        = flags.empty;
    assign almost_empty = flags.almost_empty;
    assign count        = count_q;

`ifdef NEBULA_FIFO_ASSERTIONS_EN
    // Protocol and internal-consistency checks, sampled on each active edge.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(wr_en && full))
                else $error("nebula_sync_fifo: write attempted while full at %0t", $time);
            assert (!(rd_en && empty))
                else $error("nebula_sync_fifo: read attempted while empty at %0t", $time);
            assert (count_q <= CNT_FULL)
                else $error("nebula_sync_fifo: count exceeds depth at %0t", $time);
            assert (empty == (count_q == '0))
                else $error("nebula_sync_fifo: empty inconsistent with count at %0t", $time);
            assert (full == (count_q == CNT_FULL))
                else $error("nebula_sync_fifo: full inconsistent with count at %0t", $time);
        end
    end
`else
    // Assertions not compiled; behaviour is identical.
`endif

endmodule : nebula_sync_fifo

// File: tb/tb_nebula_sync_fifo.sv
// tb_nebula_sync_fifo: directed and randomized self-checking bench for
// nebula_sync_fifo. The reference model is a plain queue of words.
module tb_nebula_sync_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AFT   = DEPTH - 2;
    localparam int AET   = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          almost_empty;
    logic [CW-1:0] count;

    logic [DW-1:0] model_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    nebula_sync_fifo #(
        .DATA_WIDTH          (DW),
        .DEPTH               (DEPTH),
        .ALMOST_FULL_THRESH  (AFT),
        .ALMOST_EMPTY_THRESH (AET)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the queue model implies.
    task automatic check_state(input string ctx);
        int n;
        n = model_q.size();
        check({ctx, ".count"},        32'(count),   32'(n));
        check({ctx, ".empty"},        32'(empty),   32'(n == 0));
        check({ctx, ".full"},         32'(full),    32'(n == DEPTH));
        check({ctx, ".almost_empty"}, 32'(almost_empty), 32'(n <= AET));
        check({ctx, ".almost_full"},  32'(almost_full),  32'(n >= AFT));
        check({ctx, ".rd_data"},      rd_data, (n == 0) ? 32'h0 : model_q[0]);
    endtask

    // One clock cycle of stimulus; the model applies the FIFO rules.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
        bit w_ok;
        bit r_ok;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        w_ok = we && (model_q.size() < DEPTH);
        r_ok = re && (model_q.size() != 0);
        if (r_ok) check("head_before_pop", rd_data, model_q[0]);
        @(posedge clk);
        #1;
        if (r_ok) void'(model_q.pop_front());
        if (w_ok) model_q.push_back(wd);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Hold reset for three edges with requests active; they must be ignored.
    task automatic do_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = $urandom;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_q.delete();
    endtask

    initial begin
        logic [DW-1:0] pats [4];
        pats[0] = 32'h0000_0000;
        pats[1] = 32'hFFFF_FFFF;
        pats[2] = 32'hAAAA_AAAA;
        pats[3] = 32'h5555_5555;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        #1;

        // Reset state.
        do_reset();
        check_state("reset");
        check("reset.rd_data_zero", rd_data, 32'h0);
        check("reset.almost_full", 32'(almost_full), 32'h0);

        // Single write, then single read.
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        check("wr1.rd_data", rd_data, 32'hDEAD_BEEF);
        check("wr1.count", 32'(count), 32'd1);
        step(1'b0, '0, 1'b1);
        check("rd1.count", 32'(count), 32'd0);
        check("rd1.empty", 32'(empty), 32'd1);

        // Fill to full, then pop in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(100 + i), 1'b0);
        check("fill.full", 32'(full), 32'd1);
        check("fill.count", 32'(count), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            check("pop_seq", rd_data, 32'(100 + i));
            step(1'b0, '0, 1'b1);
        end
        check_state("drained");

        // Almost-empty / almost-full thresholds.
        step(1'b1, 32'd200, 1'b0);
        step(1'b1, 32'd201, 1'b0);
        check("cnt2.almost_empty", 32'(almost_empty), 32'd1);
        step(1'b1, 32'd202, 1'b0);
        check("cnt3.almost_empty", 32'(almost_empty), 32'd0);
        step(1'b1, 32'd203, 1'b0);
        step(1'b1, 32'd204, 1'b0);
        check("cnt5.almost_full", 32'(almost_full), 32'd0);
        step(1'b1, 32'd205, 1'b0);
        check("cnt6.almost_full", 32'(almost_full), 32'd1);
        check("cnt6.almost_empty", 32'(almost_empty), 32'd0);
        step(1'b0, '0, 1'b1);
        check("cnt5b.almost_full", 32'(almost_full), 32'd0);
        while (model_q.size() != 0) step(1'b0, '0, 1'b1);
        check_state("thresh_drain");

        // Simultaneous read and write with three words queued.
        step(1'b1, 32'd300, 1'b0);
        step(1'b1, 32'd301, 1'b0);
        step(1'b1, 32'd302, 1'b0);
        check("rw.head_before", rd_data, 32'd300);
        step(1'b1, 32'hCAFE_BABE, 1'b1);
        check("rw.count", 32'(count), 32'd3);
        check("rw.head_after", rd_data, 32'd301);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check("rw.last_word", rd_data, 32'hCAFE_BABE);
        step(1'b0, '0, 1'b1);
        check_state("rw_drain");

        // Write while full is dropped; read+write while full only reads.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(400 + i), 1'b0);
        step(1'b1, 32'hDEAD_DEAD, 1'b0);
        check("full_wr.count", 32'(count), 32'd8);
        check_state("full_wr");
        step(1'b1, 32'hBAD0_BAD0, 1'b1);
        check("full_rw.count", 32'(count), 32'd7);
        check_state("full_rw");
        while (model_q.size() != 0) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check("empty_rd.count", 32'(count), 32'd0);
        check("empty_rd.empty", 32'(empty), 32'd1);

        // Empty with both enables: only the write lands.
        step(1'b1, 32'h0000_0077, 1'b1);
        check("empty_rw.count", 32'(count), 32'd1);
        check("empty_rw.rd_data", rd_data, 32'h0000_0077);
        step(1'b0, '0, 1'b1);

        // Data patterns across several pointer wraps.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) step(1'b1, pats[k], 1'b0);
            for (int k = 0; k < 4; k++) begin
                check("pattern", rd_data, pats[k]);
                step(1'b0, '0, 1'b1);
            end
        end
        check_state("patterns");

        // Randomized traffic with alternating write/read bias.
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (((i / 40) % 2) == 0) ? 75 : 25;
            step(($urandom_range(99) < bias), $urandom, ($urandom_range(99) < (100 - bias)));
            check_state("random");
        end

        // Reset in the middle of traffic clears occupancy.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(500 + i), 1'b0);
        do_reset();
        check_state("mid_reset");
        step(1'b1, 32'h1234_5678, 1'b0);
        check("post_reset.rd_data", rd_data, 32'h1234_5678);
        check_state("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nebula_sync_fifo
